mem_stage: RTL

Memory-access stage of the RV64I five-stage pipeline. It consumes an `execute_data_t` from the execute/memory boundary and performs at most one data-bus transaction per instruction using a valid/addr_ok/data_ok handshake. It aligns and extends load data, and registers a `memory_data_t` for writeback. Non-memory instructions pass through in one cycle. Memory operations stall upstream until the bus completes.

---
 rtl/mem_stage_pkg.sv | 75 +++++++
 rtl/mem_stage_align.sv | 45 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline and data-bus types for the memory stage: bus request/response
// records, control fields, stage records and the bus handshake state enum.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_LOAD  = 2'b01;
  localparam logic [1:0] MEMRW_STORE = 2'b10;
  localparam logic [1:0] WB_PC4      = 2'd2;

  typedef struct packed {
    logic       RegWrite;
    logic [4:0] wa;
    logic [1:0] MemRW;
    msize_t     msize;
    logic       mem_unsigned;
    logic       loadEn;
    logic [1:0] WBSel;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] alu;
    logic [63:0] rs2;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] result;
    logic        addr31;
  } memory_data_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } mem_state_t;

  // Natural alignment check on the low address bits.
  function automatic logic is_misaligned(input msize_t size, input logic [2:0] offset);
    case (size)
      MSIZE2:  is_misaligned = offset[0];
      MSIZE4:  is_misaligned = |offset[1:0];
      MSIZE8:  is_misaligned = |offset;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane logic for the memory stage: store strobe/data placement within the
// 64-bit bus word, and load lane extraction with zero/sign extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  msize_t      i_size,
  input  logic [2:0]  i_offset,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_load_raw,
  input  logic        i_unsigned,
  output strobe_t     o_strobe,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shamt;
  strobe_t     w_base_strobe;
  logic [63:0] w_lane;

  assign w_shamt = {i_offset, 3'b000};

  always_comb begin
    case (i_size)
      MSIZE1:  w_base_strobe = 8'h01;
      MSIZE2:  w_base_strobe = 8'h03;
      MSIZE4:  w_base_strobe = 8'h0F;
      default: w_base_strobe = 8'hFF;
    endcase
  end

  // Bytes shifted past lane 7 are dropped, never wrapped.
  assign o_strobe = w_base_strobe << i_offset;
  assign o_wdata  = i_store_data << w_shamt;
  assign w_lane   = i_load_raw >> w_shamt;

  always_comb begin
    case (i_size)
      MSIZE1:  o_rdata = i_unsigned ? {56'd0, w_lane[7:0]}  : {{56{w_lane[7]}},  w_lane[7:0]};
      MSIZE2:  o_rdata = i_unsigned ? {48'd0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
      MSIZE4:  o_rdata = i_unsigned ? {32'd0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
      default: o_rdata = w_lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one valid/addr_ok/data_ok bus transaction per
// memory instruction. Optional misaligned-access trap via MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  execute_data_t dataE,
  output memory_data_t  dataM,
  output logic          stallM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);

  mem_state_t   r_state;
  memory_data_t w_next;
  logic         w_is_mem;
  logic         w_is_store;
  logic         w_misalign;
  logic         w_bus_op;
  logic         w_done;
  strobe_t      w_strobe;
  logic [63:0]  w_wdata;
  logic [63:0]  w_rdata;

  assign w_is_mem   = dataE.valid && (dataE.ctl.MemRW != MEMRW_NONE);
  assign w_is_store = dataE.ctl.MemRW == MEMRW_STORE;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign = w_is_mem && is_misaligned(dataE.ctl.msize, dataE.alu[2:0]);
  assign misalign   = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // A trapped access never reaches the bus.
  assign w_bus_op = w_is_mem && !w_misalign;

  mem_align u_align (
    .i_size       (dataE.ctl.msize),
    .i_offset     (dataE.alu[2:0]),
    .i_store_data (dataE.rs2),
    .i_load_raw   (dresp.data),
    .i_unsigned   (dataE.ctl.mem_unsigned),
    .o_strobe     (w_strobe),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata)
  );

  always_comb begin
    case (r_state)
      IDLE, WAIT_ADDR: w_done = dresp.addr_ok && dresp.data_ok;
      WAIT_DATA:       w_done = dresp.data_ok;
      default:         w_done = 1'b0;
    endcase
  end

  assign stallM = w_bus_op && !w_done;

  // Request is masked while reset is held so an abandoned request drops at once.
  always_comb begin
    dreq        = '0;
    dreq.valid  = resetn && w_bus_op && (r_state != WAIT_DATA);
    dreq.addr   = dataE.alu;
    dreq.size   = dataE.ctl.msize;
    dreq.strobe = w_is_store ? w_strobe : 8'h00;
    dreq.data   = w_wdata;
  end

  always_comb begin
    w_next        = '0;
    w_next.valid  = dataE.valid;
    w_next.pc     = dataE.pc;
    w_next.ctl    = dataE.ctl;
    w_next.addr31 = w_is_mem ? dataE.alu[31] : 1'b1;
    if (w_misalign)
      w_next.result = 64'd0;
    else if (dataE.ctl.loadEn)
      w_next.result = w_rdata;
    else if (dataE.ctl.WBSel == WB_PC4)
      w_next.result = dataE.pc + 64'd4;
    else
      w_next.result = dataE.alu;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      dataM   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_bus_op) begin
            if (!dresp.addr_ok)
              r_state <= WAIT_ADDR;
            else if (!dresp.data_ok)
              r_state <= WAIT_DATA;
          end
        end
        WAIT_ADDR: begin
          if (dresp.addr_ok)
            r_state <= dresp.data_ok ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: begin
          if (dresp.data_ok)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (!stallM) begin
        dataM <= w_next;
`ifdef MEM_MISALIGN_TRAP_EN
        r_misalign <= w_misalign;
`endif
      end else begin
        dataM.valid <= 1'b0;
      end
    end
  end

endmodule
